// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART constants and the transmit-arbiter state encoding
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SEND      = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// rr_pick : round-robin pick, first asserted request after 'last' (wrapping)
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic            valid,
   output logic [IW-1:0]   idx
);

   logic [IW-1:0] w_cand;

   // Walk from the farthest offset down so the nearest hit after 'last' wins.
   always_comb begin
      valid  = 1'b0;
      idx    = '0;
      w_cand = '0;
      for (int k = NREQ; k >= 1; k--) begin
         w_cand = IW'((int'(last) + k) % NREQ);
         if (req[w_cand]) begin
            valid = 1'b1;
            idx   = w_cand;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter : round-robin sharing of one 8N1 transmitter among NREQ producers
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NREQ-1:0]             req,
   input  logic [UART_DATA_W*NREQ-1:0] req_data,
   output logic [NREQ-1:0]             ack,
   output logic [IW-1:0]               grant_id,
   output logic                        busy,
   output logic                        senddata,
   output logic [UART_DATA_W-1:0]      txbyte,
   input  logic                        txdone
);

   arb_state_t             r_state, w_state_nx;
   logic [IW-1:0]          r_last, w_last_nx;
   logic [IW-1:0]          r_grant_id, w_grant_nx;
   logic [NREQ-1:0]        r_ack, w_ack_nx;
   logic                   r_senddata, w_senddata_nx;
   logic                   r_busy;
   logic [UART_DATA_W-1:0] r_txbyte, w_txbyte_nx;
   logic                   w_pick_valid;
   logic [IW-1:0]          w_pick_idx;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req   (req),
      .last  (r_last),
      .valid (w_pick_valid),
      .idx   (w_pick_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx    = r_state;
      w_last_nx     = r_last;
      w_grant_nx    = r_grant_id;
      w_txbyte_nx   = r_txbyte;
      w_ack_nx      = '0;
      w_senddata_nx = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (txdone && w_pick_valid) begin
               w_state_nx    = ST_SEND;
               w_senddata_nx = 1'b1;
               w_grant_nx    = w_pick_idx;
               w_last_nx     = w_pick_idx;
               for (int i = 0; i < NREQ; i++) begin
                  if (w_pick_idx == IW'(i)) begin
                     w_ack_nx[i] = 1'b1;
                     w_txbyte_nx = req_data[UART_DATA_W*i +: UART_DATA_W];
                  end
               end
            end
         end
         ST_SEND:      w_state_nx = ST_WAIT_BUSY;
         // txdone still high here means the transmitter has not latched yet.
         ST_WAIT_BUSY: if (!txdone) w_state_nx = ST_WAIT_DONE;
         ST_WAIT_DONE: if (txdone)  w_state_nx = ST_IDLE;
         default:      w_state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last     <= IW'(NREQ - 1);
         r_grant_id <= '0;
         r_txbyte   <= '0;
         r_ack      <= '0;
         r_senddata <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_last     <= w_last_nx;
         r_grant_id <= w_grant_nx;
         r_txbyte   <= w_txbyte_nx;
         r_ack      <= w_ack_nx;
         r_senddata <= w_senddata_nx;
         r_busy     <= (w_state_nx != ST_IDLE);
      end
   end

   assign ack      = r_ack;
   assign grant_id = r_grant_id;
   assign busy     = r_busy;
   assign senddata = r_senddata;
   assign txbyte   = r_txbyte;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// tb_uart_tx_arbiter : directed scoreboard bench for uart_tx_arbiter
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = 4'b0;
   logic [31:0] req_data = 32'h3CA5960F;   // bytes: 3=3C 2=A5 1=96 0=0F
   logic [3:0]  ack;
   logic [1:0]  grant_id;
   logic        busy;
   logic        senddata;
   logic [7:0]  txbyte;
   logic        txdone = 1'b1;
   logic        model_en = 1'b1;
   int          tx_cnt = 0;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int         id;
      logic [7:0] b;
   } exp_t;
   exp_t exp_q[$];

   uart_tx_arbiter #(.NREQ(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_data (req_data),
      .ack      (ack),
      .grant_id (grant_id),
      .busy     (busy),
      .senddata (senddata),
      .txbyte   (txbyte),
      .txdone   (txdone)
   );

   always #5 clk = ~clk;

   // Transmitter model: txdone drops the edge after senddata, stays low 10 cycles.
   always @(posedge clk) begin
      if (model_en) begin
         if (tx_cnt != 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) txdone <= 1'b1;
         end else if (senddata) begin
            txdone <= 1'b0;
            tx_cnt <= 10;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int id, input logic [7:0] b);
      exp_t e;
      e.id = id;
      e.b  = b;
      exp_q.push_back(e);
   endtask

   // Monitor: every grant the DUT presents is popped and compared.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (ack != 4'b0 || senddata)) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_grant: got ack=%b senddata=%b expected no grant", ack, senddata);
         end else begin
            e = exp_q.pop_front();
            chk("grant_ack",      ack,      32'(1) << e.id);
            chk("grant_senddata", senddata, 1);
            chk("grant_id",       grant_id, e.id);
            chk("grant_txbyte",   txbyte,   e.b);
         end
      end
   end

   task automatic wait_ack(input bit hold, output int cyc);
      cyc = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         cyc++;
         if (ack != 4'b0) break;
      end
      chk("ack_seen", (ack != 4'b0), 1);
      if (!hold) req = req & ~ack;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy && txdone) break;
      end
      chk("idle_reached", (!busy && txdone), 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_senddata"}, senddata, 0);
      chk({tag, "_ack"},      ack,      0);
      chk({tag, "_txbyte"},   txbyte,   8'h00);
      chk({tag, "_grant_id"}, grant_id, 0);
      chk({tag, "_busy"},     busy,     0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      // Single request, exact one-cycle latency then deassertion.
      @(negedge clk);
      req = 4'b0100;
      push(2, 8'hA5);
      wait_ack(0, cyc);
      chk("single_latency", cyc, 1);
      @(negedge clk);
      chk("single_senddata_low", senddata, 0);
      chk("single_ack_low",      ack,      0);
      wait_idle();

      // Fairness from a fresh pointer: 0,1,2,3,0 with all requests held.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req = 4'b1111;
      push(0, 8'h0F); push(1, 8'h96); push(2, 8'hA5); push(3, 8'h3C); push(0, 8'h0F);
      for (int k = 0; k < 5; k++) wait_ack(1, cyc);
      req = 4'b0;
      wait_idle();

      // Wrap: move pointer to 3, then 1001 held gives 0 then 3.
      req = 4'b1000;
      push(3, 8'h3C);
      wait_ack(0, cyc);
      wait_idle();
      req = 4'b1001;
      push(0, 8'h0F); push(3, 8'h3C);
      wait_ack(1, cyc);
      wait_ack(1, cyc);
      req = 4'b0;
      wait_idle();

      // Busy gating: request raised two cycles into WAIT_DONE.
      req = 4'b0001;
      push(0, 8'h0F);
      wait_ack(0, cyc);
      repeat (4) @(negedge clk);
      req = 4'b0100;
      push(2, 8'hA5);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (txdone) break;
         chk("gate_no_ack", ack, 0);
      end
      @(negedge clk);
      chk("gate_idle_cycle_ack", ack, 0);
      @(negedge clk);
      chk("gate_first_idle_grant", ack, 4'b0100);
      req = req & ~ack;
      wait_idle();

      // Reset mid-frame while txdone is low.
      req = 4'b1000;
      push(3, 8'h3C);
      wait_ack(0, cyc);
      repeat (3) @(negedge clk);
      req = 4'b0010;
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("midreset");
      rst = 1'b0;
      push(1, 8'h96);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (txdone) break;
         chk("midreset_no_ack", ack, 0);
      end
      wait_ack(0, cyc);
      wait_idle();

      // Stuck txdone: hold in WAIT_BUSY, no new triggers even with a request.
      model_en = 1'b0;
      req = 4'b0100;
      push(2, 8'hA5);
      wait_ack(0, cyc);
      req = 4'b0001;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("stuck_hold", {busy, senddata, ack}, 6'b100000);
      end
      req = 4'b0;

      repeat (2) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single 8N1 transmitter (`uart_tx_8n1`) among `NREQ` byte producers, e.g. the echo path, a status reporter and a debug dumper. It grants one requester at a time and drives the transmitter's `senddata`/`txbyte` inputs. It tracks each frame through the transmitter's `txdone` and starts the next grant only after the current frame's stop bit completes. It sits between the producers and `uart_tx_8n1`, and is clocked by the same `clk` as the transmitter.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters; legal range 2..16.
- `IW`, default `$clog2(NREQ)`: width of the grant index; derived, never overridden.

Ports:
- `clk`  in  1: single clock, shared with `uart_tx_8n1`.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  NREQ: per-requester level request; held high with data stable until its `ack`.
- `req_data`  in  8*NREQ: byte i occupies `req_data[8*i+7:8*i]`.
- `ack`  out  NREQ: one-cycle pulse; byte i accepted.
- `grant_id`  out  IW: index of the last granted requester.
- `busy`  out  1: high whenever state != IDLE.
- `senddata`  out  1: one-cycle trigger to the transmitter.
- `txbyte`  out  8: byte to the transmitter; held from grant until the next grant.
- `txdone`  in  1: transmitter idle/done flag.

## Operation
- All outputs are registered.
- Reset values:
  - state = IDLE
  - `senddata`=0, `ack`=0, `txbyte`=8'h00, `grant_id`=0, `busy`=0
  - round-robin pointer `last` = NREQ-1, so requester 0 has first priority.
- Pick rule: the first asserted `req[i]` searching `last+1, last+2, ...`, with the index wrapping modulo NREQ.
- States:
  - IDLE: if `txdone`=1 and `req`!=0, then:
    - grant g = pick
    - `senddata`<=1, `ack[g]`<=1, `txbyte`<=req_data[g]
    - `grant_id`<=g, `last`<=g
    - go to SEND.
    If `txdone`=0, stay in IDLE and grant nothing.
  - SEND: clear `senddata` and `ack`; go to WAIT_BUSY.
  - WAIT_BUSY: when `txdone`=0, go to WAIT_DONE. Otherwise hold (the transmitter has not yet latched the byte).
  - WAIT_DONE: when `txdone`=1, go to IDLE.
- `req` is ignored in SEND, WAIT_BUSY and WAIT_DONE. A request still held after its `ack` is therefore not double-granted; a producer that keeps `req` high after `ack` is treated as a new request at the next IDLE.
- Requests arriving while busy are served in round-robin order once IDLE is reached.
- Reset mid-frame: the arbiter returns to IDLE and clears its outputs. The transmitter is not reset by this block, so the in-flight frame completes. No grant is issued until `txdone`=1.

## Timing
- Request seen in IDLE at cycle t → `senddata`, `ack[g]` and the new `txbyte` are high/valid at t+1 only.
- The transmitter latches the byte at the end of t+1, and `txdone` falls at t+2. The arbiter reaches WAIT_DONE at t+3.
- Back-to-back grants: the cycle the arbiter enters IDLE with `txdone`=1 and `req`!=0 is itself a grant-decision cycle. There is no extra idle cycle.
- Worst-case wait for a continuously asserted requester: NREQ-1 full frames.
- `ack` is never asserted for more than one requester at a time, nor for more than one cycle per grant.

## Structure
- Shared package `uart_pkg`:
  - `UART_DATA_W`=8
  - arbiter state typedef (IDLE, SEND, WAIT_BUSY, WAIT_DONE as 2-bit encodings 0..3).
- Sub-module `rr_pick`: combinational rotate-and-priority-encode of `req` relative to `last`. It outputs `valid` and `idx`, and is reusable by other arbiters.
- The top level contains the FSM, the output registers and the `last` pointer.

## Test plan
- Single request: `req`=4'b0100, `req_data[23:16]`=8'hA5, `txdone`=1 → at t+1, `senddata`=1, `ack`=4'b0100, `txbyte`=8'hA5, `grant_id`=2. `senddata` and `ack` are low at t+2.
- Round-robin fairness: `req`=4'b1111 held, with a transmitter model dropping `txdone` for 10 cycles per frame → grant order 0,1,2,3,0. Exactly one `ack` pulse per frame.
- Wrap: `last`=3 and `req`=4'b1001 → grant 0. Next frame, with `req`=4'b1001 still held → grant 3.
- Busy gating: request asserted at WAIT_DONE plus 2 cycles → no `ack` until `txdone` rises. The grant then follows on the first IDLE cycle.
- Reset mid-frame: assert `rst` in WAIT_DONE with `txdone`=0 and `req`=4'b0010 → all outputs return to reset values. No grant occurs until `txdone`=1, after which requester 1 is granted.
- Stuck txdone: `txdone` stays 1 after `senddata` → the FSM holds in WAIT_BUSY, with no further `senddata` and no `ack`.
